// File: rtl/apb_arb_pkg.sv
// Shared definitions for apb_requester_arbiter: FSM state encoding,
// index-width helper and the default ACCESS-phase timeout.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a registered
// pointer; the pointer moves past the winner on each advance strobe.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    gnt_o = '0;
    idx_o = '0;
    sum   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  assign ptr_d = (idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : idx_o + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ptr_q <= '0;
    else if (advance_i) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/apb_requester_arbiter.sv
// APB requester sharing one completer between NUM_REQ local requesters.
// Optional ACCESS-phase timeout abort is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_requester_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                          m_apb_aclk,
  input  logic                          m_apb_aresetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_slverr,
  output logic [ADDR_WIDTH-1:0]         m_apb_paddr,
  output logic                          m_apb_psel,
  output logic                          m_apb_penable,
  output logic                          m_apb_pwrite,
  output logic [DATA_WIDTH-1:0]         m_apb_pwdata,
  input  logic [DATA_WIDTH-1:0]         m_apb_prdata,
  input  logic                          m_apb_pready,
  input  logic                          m_apb_pslverr
);

  localparam int IDX_W = clog2(NUM_REQ);

  logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  advance;
  apb_state_e            state_q;
  logic [IDX_W-1:0]      owner_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  psel_q, penable_q, pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_slverr_q;

  assign advance = (state_q == IDLE) && (|req_valid);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (m_apb_aclk),
    .rst_n     (m_apb_aresetn),
    .req_i     (req_valid),
    .advance_i (advance),
    .gnt_o     (gnt),
    .idx_o     (gnt_idx)
  );

  // The only unregistered output; held low during reset like everything else.
  assign req_ready = (advance && m_apb_aresetn) ? gnt : '0;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMO_W = clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_cnt_q;
`endif

  always_ff @(posedge m_apb_aclk or negedge m_apb_aresetn) begin
    if (!m_apb_aresetn) begin
      // NOTE: datapath registers are cleared too, so every output reads 0 straight out of reset.
      state_q      <= IDLE;
      owner_q      <= '0;
      paddr_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: if (advance) begin
          state_q   <= SETUP;
          owner_q   <= gnt_idx;
          psel_q    <= 1'b1;
          penable_q <= 1'b0;
          paddr_q   <= addr_a[gnt_idx];
          pwrite_q  <= req_write[gnt_idx];
          pwdata_q  <= req_write[gnt_idx] ? wdata_a[gnt_idx] : '0;
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        ACCESS: begin
          if (m_apb_pready) begin
            state_q              <= IDLE;
            psel_q               <= 1'b0;
            penable_q            <= 1'b0;
            rsp_valid_q[owner_q] <= 1'b1;
            rsp_rdata_q          <= pwrite_q ? '0 : m_apb_prdata;
            rsp_slverr_q         <= m_apb_pslverr;
          end
`ifdef APB_ARB_TIMEOUT_EN
          // Last allowed ACCESS cycle without pready: abort with an error response.
          else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_q              <= IDLE;
            psel_q               <= 1'b0;
            penable_q            <= 1'b0;
            rsp_valid_q[owner_q] <= 1'b1;
            rsp_rdata_q          <= '0;
            rsp_slverr_q         <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_slverr    = rsp_slverr_q;
  assign m_apb_paddr   = paddr_q;
  assign m_apb_psel    = psel_q;
  assign m_apb_penable = penable_q;
  assign m_apb_pwrite  = pwrite_q;
  assign m_apb_pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_requester_arbiter.sv
// Self-checking bench for apb_requester_arbiter: directed vector table, hand
// sequences for reset/timeout/fairness corners, and a randomized scoreboard run.
module tb_apb_requester_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NR  = 2;
  localparam int TMO = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR-1:0]    req_write = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_slverr;
  logic [AW-1:0]    paddr;
  logic             psel, penable, pwrite;
  logic [DW-1:0]    pwdata;
  logic [DW-1:0]    prdata = '0;
  logic             pready = 1'b0;
  logic             pslverr = 1'b0;

  always #5 clk = ~clk;

  apb_requester_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .m_apb_aclk(clk), .m_apb_aresetn(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .m_apb_paddr(paddr), .m_apb_psel(psel), .m_apb_penable(penable),
    .m_apb_pwrite(pwrite), .m_apb_pwdata(pwdata), .m_apb_prdata(prdata),
    .m_apb_pready(pready), .m_apb_pslverr(pslverr)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic drive_req(input int g, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[g]         = 1'b1;
    req_write[g]         = wr;
    req_addr[g*AW +: AW] = a;
    req_wdata[g*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    @(negedge clk); #1 rst_n = 1'b0;
    req_valid = '0;
    pready    = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    int          g;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_pwdata;
    logic [31:0] exp_rdata;
    logic        exp_slverr;
  } vec_t;

  // One isolated transfer from an idle DUT, checked phase by phase.
  task automatic do_xfer(input vec_t v);
    @(posedge clk); #1;
    req_valid = '0;
    drive_req(v.g, v.wr, v.addr, v.wdata);
    @(negedge clk);
    check("accept_ready", req_ready, oh(v.g));
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    check("setup_psel", psel, 1);
    check("setup_penable", penable, 0);
    check("setup_paddr", paddr, v.addr);
    check("setup_pwrite", pwrite, v.wr);
    check("setup_pwdata", pwdata, v.exp_pwdata);
    for (int i = 0; i <= v.waits; i++) begin
      @(posedge clk); #1;
      pready  = (i == v.waits);
      prdata  = (i == v.waits) ? v.prdata : $urandom;
      pslverr = (i == v.waits) ? v.slverr : 1'($urandom_range(0, 1));
      @(negedge clk);
      check("access_psel", {psel, penable}, 2'b11);
      check("access_paddr", paddr, v.addr);
      check("access_pwdata", pwdata, v.exp_pwdata);
      check("access_no_rsp", rsp_valid, '0);
    end
    @(posedge clk); #1;
    pready = 1'b0;
    prdata = $urandom;
    @(negedge clk);
    check("rsp_valid", rsp_valid, oh(v.g));
    check("rsp_rdata", rsp_rdata, v.exp_rdata);
    check("rsp_slverr", rsp_slverr, v.exp_slverr);
    check("rsp_psel_low", {psel, penable}, 2'b00);
  endtask

  // Randomized requesters and completer against a transaction-level scoreboard.
  task automatic run_random(input int ncyc);
    bit          rv[NR], busy[NR], rwr[NR];
    logic [31:0] raddr[NR], rwdata[NR];
    bit          act;
    int          t_acc, w_m, g_m, gp, idx, ptr_m;
    logic        wr_m, err_m;
    logic [31:0] addr_m, wdata_m, prd_m;
    logic [NR-1:0] exp_rsp;
    act   = 1'b0;
    ptr_m = 0;
    t_acc = 0; w_m = 0; g_m = 0;
    wr_m = 1'b0; err_m = 1'b0; addr_m = '0; wdata_m = '0; prd_m = '0;
    for (int i = 0; i < NR; i++) begin
      rv[i] = 1'b0; busy[i] = 1'b0; rwr[i] = 1'b0; raddr[i] = '0; rwdata[i] = '0;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (!rv[i] && !busy[i] && $urandom_range(0, 2) == 0) begin
          rv[i]     = 1'b1;
          rwr[i]    = 1'($urandom_range(0, 1));
          raddr[i]  = $urandom;
          rwdata[i] = $urandom;
        end
        req_valid[i] = rv[i];
        req_write[i] = rwr[i];
        req_addr[i*AW +: AW]  = raddr[i];
        req_wdata[i*DW +: DW] = rwdata[i];
      end
      if (act && c == t_acc + 2 + w_m) begin
        pready = 1'b1; prdata = prd_m; pslverr = err_m;
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      gp = -1;
      if (!act || c >= t_acc + 3 + w_m)
        for (int k = 0; k < NR; k++) begin
          idx = (ptr_m + k) % NR;
          if (gp < 0 && rv[idx]) gp = idx;
        end
      check("rnd_ready", req_ready, (gp < 0) ? '0 : oh(gp));
      check("rnd_psel", psel, act && c >= t_acc + 1 && c <= t_acc + 2 + w_m);
      check("rnd_penable", penable, act && c >= t_acc + 2 && c <= t_acc + 2 + w_m);
      if (act && c >= t_acc + 1 && c <= t_acc + 2 + w_m) begin
        check("rnd_paddr", paddr, addr_m);
        check("rnd_pwrite", pwrite, wr_m);
        check("rnd_pwdata", pwdata, wr_m ? wdata_m : 32'h0);
      end
      exp_rsp = (act && c == t_acc + 3 + w_m) ? oh(g_m) : '0;
      check("rnd_rsp_valid", rsp_valid, exp_rsp);
      if (exp_rsp != '0) begin
        check("rnd_rsp_rdata", rsp_rdata, wr_m ? 32'h0 : prd_m);
        check("rnd_rsp_slverr", rsp_slverr, err_m);
        busy[g_m] = 1'b0;
        act       = 1'b0;
      end
      if (gp >= 0) begin
        act     = 1'b1;
        t_acc   = c;
        g_m     = gp;
        w_m     = $urandom_range(0, 4);
        wr_m    = rwr[gp];
        addr_m  = raddr[gp];
        wdata_m = rwdata[gp];
        prd_m   = $urandom;
        err_m   = 1'($urandom_range(0, 1));
        rv[gp]   = 1'b0;
        busy[gp] = 1'b1;
        ptr_m    = (gp + 1) % NR;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t vecs[6];
  int   gl[$];
  bit   any_rsp;

  initial begin
    //             g  wr  addr          wdata         w  prdata        err exp_pwdata    exp_rdata     exp_err
    vecs[0] = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1] = '{1, 1'b0, 32'h0000_0020, 32'h0,         3, 32'hA5A5_A5A5, 1'b0, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[2] = '{0, 1'b1, 32'h0000_0030, 32'h0BAD_F00D, 1, 32'h7777_7777, 1'b1, 32'h0BAD_F00D, 32'h0,         1'b1};
    vecs[3] = '{1, 1'b0, 32'h0000_0040, 32'hFFFF_FFFF, 0, 32'h5A5A_0001, 1'b0, 32'h0,         32'h5A5A_0001, 1'b0};
    vecs[4] = '{0, 1'b0, 32'h0000_0044, 32'h0,         7, 32'hC0FF_EE00, 1'b0, 32'h0,         32'hC0FF_EE00, 1'b0};
    vecs[5] = '{1, 1'b1, 32'h0000_0048, 32'h1357_9BDF, 2, 32'h0,         1'b1, 32'h1357_9BDF, 32'h0,         1'b1};

    // Reset state, with requests pending so req_ready must also stay low.
    drive_req(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drive_req(1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_psel_penable", {psel, penable, pwrite}, 3'b000);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp_data", {rsp_rdata, rsp_slverr}, 0);
    req_valid = '0;
    #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) do_xfer(vecs[i]);

    // A request that drops while the bus is busy must never be granted.
    @(posedge clk); #1 drive_req(0, 1'b0, 32'h80, 32'h0);
    @(negedge clk);
    check("drop_first_ready", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 2'b10;
    @(negedge clk);
    check("drop_busy_ready", req_ready, 2'b00);
    @(posedge clk); #1 req_valid = 2'b00; pready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 pready = 1'b0;
    @(negedge clk);
    check("drop_rsp_valid", rsp_valid, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("drop_no_grant", {req_ready, psel}, 3'b000);
    end

    // Completer never answers: abort with the timeout, otherwise hang in ACCESS.
    @(posedge clk); #1 drive_req(0, 1'b0, 32'h70, 32'h0);
    @(negedge clk);
    check("tmo_accept", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    check("tmo_setup", {psel, penable}, 2'b10);
`ifdef APB_ARB_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("tmo_access", {psel, penable}, 2'b11);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("tmo_rsp_valid", rsp_valid, 2'b01);
    check("tmo_rsp_slverr", rsp_slverr, 1);
    check("tmo_rsp_rdata", rsp_rdata, 0);
    check("tmo_bus_idle", {psel, penable}, 2'b00);
    @(posedge clk); #1 drive_req(1, 1'b0, 32'h74, 32'h0);
    @(negedge clk);
    check("tmo_back_idle", req_ready, 2'b10);
`else
    any_rsp = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (rsp_valid != '0) any_rsp = 1'b1;
    end
    check("hang_still_access", {psel, penable}, 2'b11);
    check("hang_no_rsp", any_rsp, 0);
`endif
    apply_reset();

    // Asynchronous reset in the middle of ACCESS.
    @(posedge clk); #1 drive_req(1, 1'b0, 32'h60, 32'h0);
    @(negedge clk);
    check("mrst_accept", req_ready, 2'b10);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mrst_in_access", {psel, penable}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_bus_drop", {psel, penable}, 2'b00);
    check("mrst_no_rsp", rsp_valid, '0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1 pready = 1'b1;
    @(negedge clk);
    check("mrst_no_late_rsp", {rsp_valid, psel}, 3'b000);

    // Both requesters held valid: grants must alternate starting from 0.
    @(posedge clk); #1;
    drive_req(0, 1'b1, 32'hA0, 32'h0000_00A0);
    drive_req(1, 1'b0, 32'hB0, 32'h0);
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      check("alt_ready_onehot", $onehot0(req_ready), 1);
      if (req_ready != '0) gl.push_back(req_ready[1] ? 1 : 0);
      if (gl.size() == 6) break;
      @(posedge clk); #1;
    end
    check("alt_count", gl.size(), 6);
    foreach (gl[i]) check("alt_order", gl[i], i % 2);
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(posedge clk);
    apply_reset();

    run_random(600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_requester_arbiter.md
Name: apb_requester_arbiter

Overview:
- APB requester that shares one APB completer between N local requesters.
- Arbitrates valid/ready requests round-robin and drives the standard SETUP/ACCESS APB sequence.
- Returns read data and error status to the granted requester.
- Sits between PS-side or fabric control masters and peripherals built on the apb_completer shell.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width.
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, ACCESS-phase wait limit. Used only with APB_ARB_TIMEOUT_EN.

Ports:
- m_apb_aclk  in  1  single clock.
- m_apb_aresetn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at slice i.
- req_write  in  NUM_REQ  1 = write.
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse, one-hot.
- rsp_rdata  out  DATA_WIDTH  read data, shared, valid with rsp_valid.
- rsp_slverr  out  1  error flag, valid with rsp_valid.
- m_apb_paddr  out  ADDR_WIDTH  APB address.
- m_apb_psel  out  1  APB select.
- m_apb_penable  out  1  APB enable.
- m_apb_pwrite  out  1  APB direction.
- m_apb_pwdata  out  DATA_WIDTH  APB write data.
- m_apb_prdata  in  DATA_WIDTH  APB read data.
- m_apb_pready  in  1  APB ready.
- m_apb_pslverr  in  1  APB error.

Behaviour:
- **Reset values.** All outputs are 0. State is IDLE. Round-robin pointer is 0, so requester 0 has highest priority first.
- **IDLE.**
  - If any req_valid is high, grant the first valid requester at or after the pointer, wrapping modulo NUM_REQ.
  - In the same cycle, assert req_ready[g] combinationally.
  - On the clock edge, register paddr, pwrite and pwdata (pwdata is forced to 0 for reads), store g, set the pointer to g+1 mod NUM_REQ, and go to SETUP.
  - If no req_valid is high, stay in IDLE.
- **SETUP.** psel=1, penable=0. Exactly one cycle, then go to ACCESS.
- **ACCESS.**
  - psel=1, penable=1.
  - Address, write and wdata are held stable across SETUP and ACCESS.
  - When pready=1 is sampled:
    - register rsp_rdata (prdata for reads, 0 for writes) and rsp_slverr=pslverr;
    - pulse rsp_valid[g] on the next cycle;
    - drop psel/penable to 0;
    - go to IDLE.
  - While pready=0, stay in ACCESS with all signals held.
- **Latency.** Accept in cycle T, SETUP T+1, ACCESS from T+2. With zero wait states, rsp_valid is high at T+3. Earliest next accept is T+3, overlapping the response cycle, so a new SETUP can start at T+4.
- **Requester rules.**
  - req_valid must stay high until req_ready.
  - A requester may not issue a new request before its rsp_valid. The block does not check this; the bench treats a violation as a stimulus error.
- **Fairness.** Requester i is never starved. Worst-case wait is NUM_REQ-1 transfers.
- **Simultaneous events.**
  - Several req_valid rising together are served in pointer order.
  - A req_valid that drops before grant is not granted.
- **Mid-operation reset.** Asynchronous clear. psel/penable drop immediately, no rsp_valid is issued, and the in-flight transfer is lost.
- **Outputs.** All outputs are registered except req_ready.

Optional Feature:
- **Macro: APB_ARB_TIMEOUT_EN.**
- **Defined.**
  - A cycle counter runs in ACCESS.
  - If pready is still 0 after TIMEOUT_CYCLES ACCESS cycles, abort: psel/penable drop to 0, rsp_valid[g]=1, rsp_slverr=1, rsp_rdata=0, go to IDLE.
  - The counter clears on entry to ACCESS.
  - If pready=1 arrives in the final allowed cycle, it completes normally.
- **Undefined.** No counter. ACCESS waits indefinitely; TIMEOUT_CYCLES is ignored.

Decomposition:
- **Package apb_arb_pkg:**
  - state encoding IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10;
  - a function computing clog2 for the pointer/index width;
  - the default TIMEOUT_CYCLES constant.
- **Sub-module rr_arbiter:**
  - inputs: NUM_REQ-wide request vector, pointer, advance strobe;
  - output: one-hot grant plus encoded index;
  - purely combinational grant, registered pointer.

Test Plan:
- NUM_REQ=2, req 0 write 0x10/0xDEADBEEF, pready tied 1 -> psel T+1, penable T+2, paddr=0x10 and pwdata=0xDEADBEEF stable across both, rsp_valid[0] at T+3 with slverr=0.
- req 1 read 0x20, completer returns prdata=0xA5A5A5A5 after 3 wait states -> rsp_rdata=0xA5A5A5A5 and rsp_valid[1] one cycle after pready; psel held for all 4 ACCESS cycles.
- req 0 and req 1 held valid continuously for 6 transfers -> grants alternate 0,1,0,1,0,1; req_ready is always one-hot.
- pslverr=1 with pready on a write -> rsp_slverr=1; next transfer has slverr=0.
- Reset asserted during ACCESS -> psel/penable go to 0 without a clock edge, no rsp_valid; after release, the first grant goes to requester 0.
- With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, pready held 0 -> abort after 8 ACCESS cycles with rsp_slverr=1, rsp_rdata=0, state IDLE. Without the macro, the same stimulus -> still in ACCESS after 100 cycles.
